// File: rtl/rfrac_out_packer_if.sv
// Bundle of the stage-2 input digits and the output FIFO handshake for
// rfrac_out_packer. The master side produces digits and consumes words;
// the slave side is the packer itself.
interface rfrac_out_packer_if #(
    parameter int DW = 16
);
    // Stage-2 pipeline inputs (fixed latency, no backpressure)
    logic            in_valid;
    logic            sign_in;
    logic [DW-1:0]   B0_in;
    logic [DW-1:0]   B1_in;
    logic [DW-1:0]   B2_in;
    logic [DW-1:0]   B3_in;
    logic            OV1_in;
    logic [17:0]     OV2_in;

    // Output side (show-ahead FIFO head)
    logic            out_valid;
    logic            out_ready;
    logic [4*DW-1:0] out_data;
    logic            out_sat;

    // Status
    logic [7:0]      drop_cnt;
    logic [7:0]      sat_cnt;
    logic            err_sticky;

    modport master (
        output in_valid, sign_in, B0_in, B1_in, B2_in, B3_in, OV1_in, OV2_in,
        output out_ready,
        input  out_valid, out_data, out_sat,
        input  drop_cnt, sat_cnt, err_sticky
    );

    modport slave (
        input  in_valid, sign_in, B0_in, B1_in, B2_in, B3_in, OV1_in, OV2_in,
        input  out_ready,
        output out_valid, out_data, out_sat,
        output drop_cnt, sat_cnt, err_sticky
    );
endinterface

// File: rtl/rfrac_out_packer.sv
// Output packer for the residue-to-binary converter: registers one capture
// stage that packs {B3,B2,B1,B0} (or a saturated value on overflow), then
// queues the word in a small show-ahead FIFO. Words arriving while the FIFO
// is full (and not popping) are dropped and counted.
module rfrac_out_packer #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    rfrac_out_packer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int WW = 4 * DW;

    // Largest positive / most negative two's-complement words of width WW
    localparam logic [WW-1:0] SAT_POS   = {1'b0, {(WW-1){1'b1}}};
    localparam logic [WW-1:0] SAT_NEG   = {1'b1, {(WW-1){1'b0}}};
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            cap_valid_q, cap_valid_d;
    logic [WW-1:0]   cap_word_q,  cap_word_d;
    logic            cap_sat_q,   cap_sat_d;

    logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]   count_q,     count_d;

    logic [7:0]      drop_cnt_q,  drop_cnt_d;
    logic [7:0]      sat_cnt_q,   sat_cnt_d;
    logic            err_q,       err_d;

    // Entry = {saturated flag, packed word}; storage is not reset
    logic [WW:0]     mem [DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic            ovf;
    logic [WW-1:0]   packed_word;
    logic            fifo_nonempty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [WW:0]     head_entry;

    // Overflow detection and digit packing for the incoming stage-2 word
    always_comb begin
        ovf         = bus.OV1_in | (bus.OV2_in != 18'd0);
        packed_word = {bus.B3_in, bus.B2_in, bus.B1_in, bus.B0_in};
    end

    // Capture stage: latch packed or saturated word whenever in_valid is set
    always_comb begin
        cap_valid_d = bus.in_valid;
        cap_word_d  = cap_word_q;
        cap_sat_d   = cap_sat_q;
        if (bus.in_valid) begin
            if (ovf) begin
                cap_word_d = bus.sign_in ? SAT_NEG : SAT_POS;
                cap_sat_d  = 1'b1;
            end else begin
                cap_word_d = packed_word;
                cap_sat_d  = 1'b0;
            end
        end
    end

    // FIFO push/pop decisions; a full FIFO still accepts if it pops this edge
    always_comb begin
        fifo_nonempty = (count_q != '0);
        fifo_full     = (count_q == COUNT_MAX);
        pop           = fifo_nonempty & bus.out_ready;
        push          = cap_valid_q & (~fifo_full | pop);
        drop          = cap_valid_q & ~push;
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Saturating status counters and sticky error flag
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        sat_cnt_d  = sat_cnt_q;
        err_d      = err_q | drop;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (push && cap_sat_q && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // All control state, cleared immediately by reset_n
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_valid_q <= 1'b0;
            cap_word_q  <= '0;
            cap_sat_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_cnt_q  <= 8'd0;
            sat_cnt_q   <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_word_q  <= cap_word_d;
            cap_sat_q   <= cap_sat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
            sat_cnt_q   <= sat_cnt_d;
            err_q       <= err_d;
        end
    end

    // FIFO storage write; push is never asserted while reset holds the
    // capture stage empty, so no reset term is needed here
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cap_sat_q, cap_word_q};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Show-ahead head; masked to zero when empty so stale storage never shows
    always_comb begin
        head_entry     = mem[rd_ptr_q];
        bus.out_valid  = fifo_nonempty;
        bus.out_data   = fifo_nonempty ? head_entry[WW-1:0] : '0;
        bus.out_sat    = fifo_nonempty & head_entry[WW];
        bus.drop_cnt   = drop_cnt_q;
        bus.sat_cnt    = sat_cnt_q;
        bus.err_sticky = err_q;
    end

endmodule
